// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory port (16-bit address, 8-bit data) between the
// CPU load/store path and the DMA engine. One master owns the port at a time.
// The owner keeps the port while it keeps requesting. If the other master is
// also requesting, the owner loses the port after MAX_BURST granted accesses,
// so neither master can starve the other.
//
// Grants are combinational from the current owner and its request. Read data
// returns one cycle after a granted read. That read is tagged with a
// registered per-master rvalid.
//
// Ports
//   clk, rst                     clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata        CPU access request (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid          CPU access performed / CPU read data on rdata
//   dma_req/we/addr/wdata        DMA access request (held until dma_gnt)
//   dma_gnt, dma_rvalid          DMA access performed / DMA read data on rdata
//   mem_addr, mem_din, mem_we    data-memory port (zero while idle)
//   mem_dout                     memory read data, one cycle after address
//   rdata                        shared read return (pass-through of mem_dout)
//   owner                        debug: 0 idle, 1 CPU, 2 DMA
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  rdata,
    output logic [1:0]  owner
);

    localparam int unsigned         CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(MAX_BURST);

    // The encoding doubles as the debug owner code.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DMA  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              cpu_rvalid_q, dma_rvalid_q;

    // Owner-relative view of the two masters (X owns the port, Y waits).
    logic              x_req, y_req;
    state_e            y_state;
    logic [CNT_W-1:0]  cnt_inc;
    logic              burst_done;

    // -------------------------------------------------------------------------
    // Grants and memory-port mux. These are combinational, so an asynchronous
    // reset clears the grants and the port in the same cycle.
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default before the
    // case; a path that leaves one unassigned would infer a latch.
    always_comb begin
        cpu_gnt  = 1'b0;
        dma_gnt  = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        case (state_q)
            ST_CPU: begin
                cpu_gnt  = cpu_req;
                mem_addr = cpu_addr;
                mem_din  = cpu_wdata;
                mem_we   = cpu_we & cpu_req;
            end
            ST_DMA: begin
                dma_gnt  = dma_req;
                mem_addr = dma_addr;
                mem_din  = dma_wdata;
                mem_we   = dma_we & dma_req;
            end
            default: ;
        endcase
    end

    assign rdata      = mem_dout;
    assign owner      = state_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        x_req       = 1'b0;
        y_req       = 1'b0;
        y_state     = ST_IDLE;
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;

        case (state_q)
            ST_CPU: begin
                x_req   = cpu_req;
                y_req   = dma_req;
                y_state = ST_DMA;
            end
            ST_DMA: begin
                x_req   = dma_req;
                y_req   = cpu_req;
                y_state = ST_CPU;
            end
            default: ;
        endcase

        // In an owner state, x_req is exactly the owner's grant for this cycle.
        // The counter saturates, so an uncontested owner that has run past
        // MAX_BURST hands over right after its next access.
        cnt_inc    = (x_req && (burst_cnt_q != CNT_MAX)) ? burst_cnt_q + CNT_W'(1)
                                                         : burst_cnt_q;
        burst_done = (cnt_inc == CNT_MAX);

        case (state_q)
            ST_IDLE: begin
                burst_cnt_d = '0;
                if (cpu_req) begin
                    state_d = ST_CPU;          // CPU wins simultaneous requests
                end else if (dma_req) begin
                    state_d = ST_DMA;
                end
            end
            ST_CPU, ST_DMA: begin
                if (y_req && (burst_done || !x_req)) begin
                    state_d     = y_state;     // hand over with no dead cycle
                    burst_cnt_d = '0;
                end else if (!x_req) begin
                    state_d     = ST_IDLE;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers. rvalid follows the master that performed the read.
    // It is therefore still delivered correctly after an ownership switch.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            burst_cnt_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            cpu_rvalid_q <= cpu_gnt & ~cpu_we;
            dma_rvalid_q <= dma_gnt & ~dma_we;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// This bench drives a MAX_BURST=4 arbiter and a MAX_BURST=1 arbiter from the
// same master stimulus. It contains the following parts:
//   - A table of directed per-cycle vectors.
//   - Hand-written sequences for burst preemption, streaming and mid-burst
//     reset.
//   - A randomized run that is compared against a reference model. The model
//     tracks ownership, accesses since the last handover, and the memory
//     contents.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;

    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din, mem_dout, rdata;
    logic [1:0]  owner;

    logic        cpu_gnt1, cpu_rvalid1, dma_gnt1, dma_rvalid1, mem_we1;
    logic [15:0] mem_addr1;
    logic [7:0]  mem_din1, mem_dout1, rdata1;
    logic [1:0]  owner1;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_BURST(MB)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .rdata(rdata), .owner(owner)
    );

    dmem_arbiter #(.MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt1), .cpu_rvalid(cpu_rvalid1),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt1), .dma_rvalid(dma_rvalid1),
        .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_we(mem_we1), .mem_dout(mem_dout1),
        .rdata(rdata1), .owner(owner1)
    );

    // ---------------- memory models ----------------
    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
        mem[16'h0120] = 8'h5A;
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr] <= mem_din;
            mem_dout <= mem[mem_addr];
        end
    end

    // The MAX_BURST=1 instance gets a simple scrambled read-back.
    always @(posedge clk)
        mem_dout1 <= mem_addr1[15:8] ^ mem_addr1[7:0] ^ mem_din1 ^ {7'd0, mem_we1};

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } op_t;

    op_t cpu_q[$];
    op_t dma_q[$];
    int  glog_m[$];     // granted master per access (1 CPU, 2 DMA)
    int  glog_a[$];     // granted address per access
    int  trace0[$];     // per-cycle grant code of u_dut  ({dma_gnt,cpu_gnt})
    int  trace1[$];     // per-cycle grant code of u_dut1
    int  n_dg;
    int  mode;          // 0 plain, 1 random with model, 4 streaming
    int  cyc;

    // reference model state
    int         m_own, m_run;
    logic       m_rv_c, m_rv_d;
    logic [7:0] m_rdata;

    task automatic drive();
        cpu_req = (cpu_q.size() > 0);
        if (cpu_req) begin
            cpu_we = cpu_q[0].we; cpu_addr = cpu_q[0].addr; cpu_wdata = cpu_q[0].wdata;
        end
        dma_req = (dma_q.size() > 0);
        if (dma_req) begin
            dma_we = dma_q[0].we; dma_addr = dma_q[0].addr; dma_wdata = dma_q[0].wdata;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        cpu_q.delete(); dma_q.delete(); glog_m.delete(); glog_a.delete();
        trace0.delete(); trace1.delete();
        n_dg = 0; mode = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic push_rand(input int who);
        op_t op;
        int  n;
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) begin
            op.we    = 1'($urandom_range(0, 1));
            op.addr  = 16'h0600 + 16'($urandom_range(0, 31));
            op.wdata = 8'($urandom);
            if (who == 1) cpu_q.push_back(op);
            else          dma_q.push_back(op);
        end
    endtask

    // Compares this cycle against the model, then advances the model across
    // the coming clock edge.
    task automatic model_step();
        logic        e_cg, e_dg, e_we, mine, theirs;
        logic [15:0] e_addr;
        logic [7:0]  e_din;
        e_cg   = (m_own == 1) && cpu_req;
        e_dg   = (m_own == 2) && dma_req;
        e_we   = e_cg ? cpu_we : (e_dg ? dma_we : 1'b0);
        e_addr = (m_own == 1) ? cpu_addr  : ((m_own == 2) ? dma_addr  : 16'h0000);
        e_din  = (m_own == 1) ? cpu_wdata : ((m_own == 2) ? dma_wdata : 8'h00);
        check($sformatf("rnd%0d cpu_gnt", cyc), cpu_gnt, e_cg);
        check($sformatf("rnd%0d dma_gnt", cyc), dma_gnt, e_dg);
        check($sformatf("rnd%0d owner", cyc), owner, m_own);
        check($sformatf("rnd%0d mem_we", cyc), mem_we, e_we);
        check($sformatf("rnd%0d mem_addr", cyc), mem_addr, e_addr);
        check($sformatf("rnd%0d mem_din", cyc), mem_din, e_din);
        check($sformatf("rnd%0d rvalids", cyc), {cpu_rvalid, dma_rvalid}, {m_rv_c, m_rv_d});
        if (m_rv_c || m_rv_d) check($sformatf("rnd%0d rdata", cyc), rdata, m_rdata);

        // memory effect of this cycle's single access
        m_rv_c = e_cg && !cpu_we;
        m_rv_d = e_dg && !dma_we;
        if (e_cg || e_dg) begin
            if (e_we) ref_mem[e_addr] = e_din;
            else      m_rdata = ref_mem[e_addr];
        end

        // ownership rules
        if (m_own == 0) begin
            m_run = 0;
            m_own = cpu_req ? 1 : (dma_req ? 2 : 0);
        end else begin
            mine   = (m_own == 1) ? cpu_req : dma_req;
            theirs = (m_own == 1) ? dma_req : cpu_req;
            if (mine) m_run++;
            if (theirs && (m_run >= MB || !mine)) begin
                m_own = 3 - m_own;
                m_run = 0;
            end else if (!mine) begin
                m_own = 0;
                m_run = 0;
            end
        end
    endtask

    // One clock cycle: sample at negedge, update masters just after posedge.
    task automatic cycle();
        logic cg, dg;
        @(negedge clk);
        cg = cpu_gnt;
        dg = dma_gnt;
        trace0.push_back(int'({dg, cg}));
        trace1.push_back(int'({dma_gnt1, cpu_gnt1}));
        if (cg) begin glog_m.push_back(1); glog_a.push_back(int'(cpu_addr)); end
        if (dg) begin glog_m.push_back(2); glog_a.push_back(int'(dma_addr)); n_dg++; end
        if (mode == 1) model_step();
        if (mode == 4) begin
            check($sformatf("t4 mb1 we gated c%0d", cyc), mem_we1 & ~(cpu_gnt1 | dma_gnt1), 1'b0);
            check($sformatf("t4 mb1 rdata c%0d", cyc), rdata1, mem_dout1);
            check($sformatf("t4 mb1 rvalid excl c%0d", cyc), cpu_rvalid1 & dma_rvalid1, 1'b0);
            check($sformatf("t4 mb1 owner c%0d", cyc), owner1, {dma_gnt1, cpu_gnt1});
        end
        cyc++;
        @(posedge clk);
        #1;
        if (cg) void'(cpu_q.pop_front());
        if (dg) void'(dma_q.pop_front());
        if (mode == 1) begin
            if (cpu_q.size() == 0 && $urandom_range(0, 2) != 0) push_rand(1);
            if (dma_q.size() == 0 && $urandom_range(0, 2) != 0) push_rand(2);
        end
        drive();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        c_req, c_we;
        logic [15:0] c_addr;
        logic [7:0]  c_wd;
        logic        d_req, d_we;
        logic [15:0] d_addr;
        logic [7:0]  d_wd;
        logic        e_cg, e_dg, e_we;
        logic [15:0] e_addr;
        logic [7:0]  e_din;
        logic [1:0]  e_own;
        logic        e_crv, e_drv;
        logic [7:0]  e_rd;
    } vec_t;

    function automatic vec_t mk(
        input logic cr, input logic cw, input logic [15:0] ca, input logic [7:0] cd,
        input logic dr, input logic dw, input logic [15:0] da, input logic [7:0] dd,
        input logic ecg, input logic edg, input logic ewe, input logic [15:0] ea,
        input logic [7:0] edin, input logic [1:0] eown, input logic ecrv, input logic edrv,
        input logic [7:0] erd);
        vec_t v;
        v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wd = cd;
        v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wd = dd;
        v.e_cg = ecg; v.e_dg = edg; v.e_we = ewe; v.e_addr = ea; v.e_din = edin;
        v.e_own = eown; v.e_crv = ecrv; v.e_drv = edrv; v.e_rd = erd;
        return v;
    endfunction

    vec_t vecs[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pushed;
        logic [15:0] a;

        cyc = 0;
        // CPU read 0x0120, then the CPU releases the bus with DMA idle.
        vecs[0]  = mk(1,0,16'h0120,8'h00, 0,0,16'h0000,8'h00, 0,0,0,16'h0000,8'h00,0,0,0,8'h00);
        vecs[1]  = mk(1,0,16'h0120,8'h00, 0,0,16'h0000,8'h00, 1,0,0,16'h0120,8'h00,1,0,0,8'h00);
        vecs[2]  = mk(0,0,16'h0120,8'h00, 0,0,16'h0000,8'h00, 0,0,0,16'h0120,8'h00,1,1,0,8'h5A);
        vecs[3]  = mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,0,16'h0000,8'h00,0,0,0,8'h00);
        // Simultaneous writes: the CPU goes first, then the DMA after the CPU lets go.
        vecs[4]  = mk(1,1,16'h0200,8'h11, 1,1,16'h0300,8'h22, 0,0,0,16'h0000,8'h00,0,0,0,8'h00);
        vecs[5]  = mk(1,1,16'h0200,8'h11, 1,1,16'h0300,8'h22, 1,0,1,16'h0200,8'h11,1,0,0,8'h00);
        vecs[6]  = mk(0,1,16'h0200,8'h11, 1,1,16'h0300,8'h22, 0,0,0,16'h0200,8'h11,1,0,0,8'h00);
        vecs[7]  = mk(0,0,16'h0000,8'h00, 1,1,16'h0300,8'h22, 0,1,1,16'h0300,8'h22,2,0,0,8'h00);
        vecs[8]  = mk(0,0,16'h0000,8'h00, 0,1,16'h0300,8'h22, 0,0,0,16'h0300,8'h22,2,0,0,8'h00);
        vecs[9]  = mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,0,16'h0000,8'h00,0,0,0,8'h00);
        // DMA reads back the CPU's write. rvalid is tagged to the DMA.
        vecs[10] = mk(0,0,16'h0000,8'h00, 1,0,16'h0200,8'h00, 0,0,0,16'h0000,8'h00,0,0,0,8'h00);
        vecs[11] = mk(0,0,16'h0000,8'h00, 1,0,16'h0200,8'h00, 0,1,0,16'h0200,8'h00,2,0,0,8'h00);
        vecs[12] = mk(0,0,16'h0000,8'h00, 0,0,16'h0200,8'h00, 0,0,0,16'h0200,8'h00,2,0,1,8'h11);
        vecs[13] = mk(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,0,16'h0000,8'h00,0,0,0,8'h00);

        do_reset();
        @(negedge clk);
        check("reset owner", owner, 2'd0);
        check("reset gnts/we", {cpu_gnt, dma_gnt, mem_we}, 3'b000);
        check("reset rvalids", {cpu_rvalid, dma_rvalid}, 2'b00);
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            cpu_req = vecs[i].c_req; cpu_we = vecs[i].c_we;
            cpu_addr = vecs[i].c_addr; cpu_wdata = vecs[i].c_wd;
            dma_req = vecs[i].d_req; dma_we = vecs[i].d_we;
            dma_addr = vecs[i].d_addr; dma_wdata = vecs[i].d_wd;
            @(negedge clk);
            check($sformatf("vec%0d cpu_gnt", i), cpu_gnt, vecs[i].e_cg);
            check($sformatf("vec%0d dma_gnt", i), dma_gnt, vecs[i].e_dg);
            check($sformatf("vec%0d mem_we", i), mem_we, vecs[i].e_we);
            check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d mem_din", i), mem_din, vecs[i].e_din);
            check($sformatf("vec%0d owner", i), owner, vecs[i].e_own);
            check($sformatf("vec%0d cpu_rvalid", i), cpu_rvalid, vecs[i].e_crv);
            check($sformatf("vec%0d dma_rvalid", i), dma_rvalid, vecs[i].e_drv);
            if (vecs[i].e_crv || vecs[i].e_drv)
                check($sformatf("vec%0d rdata", i), rdata, vecs[i].e_rd);
            @(posedge clk);
            #1;
        end
        check("mem[0200] written by cpu", mem[16'h0200], 8'h11);
        check("mem[0300] written by dma", mem[16'h0300], 8'h22);

        // ---- DMA burst preempted by the CPU after MAX_BURST accesses ----
        do_reset();
        for (int i = 0; i < 16; i++)
            dma_q.push_back('{we: 1'b1, addr: 16'(16'h0300 + i), wdata: 8'(8'h40 + i)});
        drive();
        pushed = 0;
        n = 0;
        while ((cpu_q.size() + dma_q.size() > 0 || pushed == 0) && n < 100) begin
            cycle();
            n++;
            if (pushed == 0 && n_dg == 2) begin
                cpu_q.push_back('{we: 1'b1, addr: 16'h0400, wdata: 8'h77});
                pushed = 1;
                drive();
            end
        end
        check("t3 queues drained", cpu_q.size() + dma_q.size(), 0);
        check("t3 access count", glog_m.size(), 17);
        for (int k = 0; k < 17; k++) begin
            int em, ea;
            em = (k == 4) ? 1 : 2;
            ea = (k < 4) ? 16'h0300 + k : ((k == 4) ? 16'h0400 : 16'h0300 + k - 1);
            if (k < glog_m.size()) begin
                check($sformatf("t3 access%0d master", k), glog_m[k], em);
                check($sformatf("t3 access%0d addr", k), glog_a[k], ea);
            end
        end
        check("t3 cpu write landed", mem[16'h0400], 8'h77);

        // ---- Both masters streaming: 4/4 on u_dut, 1/1 on u_dut1 ----
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cpu_q.push_back('{we: 1'($urandom_range(0, 1)), addr: 16'(16'h0700 + i), wdata: 8'($urandom)});
            dma_q.push_back('{we: 1'($urandom_range(0, 1)), addr: 16'(16'h0800 + i), wdata: 8'($urandom)});
        end
        drive();
        mode = 4;
        repeat (30) cycle();
        mode = 0;
        check("t4 arbitration cycle", trace0[0], 0);
        for (int i = 1; i <= 24; i++) begin
            check($sformatf("t4 mb4 grant c%0d", i), trace0[i], (((i - 1) / 4) % 2 == 0) ? 1 : 2);
            check($sformatf("t4 mb1 grant c%0d", i), trace1[i], (((i - 1) % 2) == 0) ? 1 : 2);
        end

        // ---- Reset in the middle of a DMA write burst ----
        do_reset();
        for (int i = 0; i < 8; i++)
            dma_q.push_back('{we: 1'b1, addr: 16'(16'h0500 + i), wdata: 8'(8'hE0 + i)});
        drive();
        n = 0;
        while (glog_m.size() < 1 && n < 20) begin
            cycle();
            n++;
        end
        check("t5 burst started", glog_m.size(), 1);
        @(negedge clk);
        check("t5 dma_gnt before reset", dma_gnt, 1'b1);
        a = dma_addr;
        #1 rst = 1'b0;
        #1;
        check("t5 dma_gnt in reset", dma_gnt, 1'b0);
        check("t5 mem_we in reset", mem_we, 1'b0);
        check("t5 owner in reset", owner, 2'd0);
        check("t5 mem_addr/din in reset", {mem_addr, mem_din}, 24'h0);
        do_reset();
        check("t5 in-flight write dropped", mem[a], init_val(a));
        repeat (2) begin
            @(negedge clk);
            check("t5 idle after reset", {owner, cpu_gnt, dma_gnt, mem_we}, 5'b0);
            check("t5 no rvalid after reset", {cpu_rvalid, dma_rvalid}, 2'b00);
        end
        @(posedge clk);
        #1;

        // ---- Randomized run against the reference model ----
        do_reset();
        ref_mem = mem;
        m_own = 0; m_run = 0; m_rv_c = 1'b0; m_rv_d = 1'b0; m_rdata = '0;
        mode = 1;
        repeat (600) cycle();
        mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
